// File: rtl/instruction_fetch_if.sv
// ============================================================================
// instruction_fetch_if : instruction-memory and decode-side bus of the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_valid;
  logic             inst_accept;
  logic [1:0]       pc_next_sel;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] reg_rs1;
  logic             fault;

  modport master (
    output mem_req, mem_addr, inst, inst_pc, inst_valid, fault,
    input  mem_ack, mem_data, inst_accept, pc_next_sel, offset, reg_rs1
  );

  modport slave (
    input  mem_req, mem_addr, inst, inst_pc, inst_valid, fault,
    output mem_ack, mem_data, inst_accept, pc_next_sel, offset, reg_rs1
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : PC owner, single-outstanding instruction fetch with next-PC select
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          WIDTH        = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [WIDTH-1:0] c_STEP     = WIDTH'(4);
  localparam logic [WIDTH-1:0] c_CLR_BIT0 = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_target;
  logic             w_bad_target;
  logic             w_capture;

  // Candidate next PC; only meaningful while an instruction is being accepted.
  always_comb begin
    w_target     = r_pc + c_STEP;
    w_bad_target = 1'b0;
    case (bus.pc_next_sel)
      2'b00:   w_target = r_pc + c_STEP;
      2'b01:   w_target = bus.inst_pc + bus.offset;
      2'b10:   w_target = (bus.reg_rs1 + bus.offset) & c_CLR_BIT0;
      default: begin
        w_target     = r_pc;
        w_bad_target = 1'b1;
      end
    endcase
    if (w_target[1:0] != 2'b00) begin
      w_bad_target = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        if (bus.mem_ack) begin
          w_capture    = 1'b1;
          w_state_next = VALID;
        end
      end
      VALID: begin
        if (bus.inst_accept) begin
          if (w_bad_target) begin
            w_state_next = FAULT;
          end else begin
            w_pc_next    = w_target;
            w_state_next = FETCH;
          end
        end
      end
      default: begin
        w_state_next = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Status outputs are flopped from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_req    <= 1'b0;
      bus.inst_valid <= 1'b0;
      bus.fault      <= 1'b0;
      bus.inst       <= '0;
      bus.inst_pc    <= '0;
    end else begin
      bus.mem_req    <= (w_state_next == FETCH);
      bus.inst_valid <= (w_state_next == VALID);
      bus.fault      <= (w_state_next == FAULT);
      if (w_capture) begin
        bus.inst    <= bus.mem_data;
        bus.inst_pc <= r_pc;
      end
    end
  end

  assign bus.mem_addr = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed corner sequences, a next-PC vector table,
// and a randomized run against a transaction-level reference model.
`default_nettype none

module tb_instruction_fetch;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_fetch_if #(.WIDTH(32)) bus ();

  instruction_fetch #(
    .RESET_VECTOR(32'h0000_0000),
    .WIDTH       (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          rst_before;
    logic [1:0]  sel;
    logic [31:0] off;
    logic [31:0] rs1;
    logic [31:0] exp_addr;
    bit          exp_fault;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0050_0093;
  endfunction

  // Reference: next PC from the architectural rules, plus whether it faults.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] sel,
                                             input logic [31:0] off, input logic [31:0] rs1,
                                             output bit flt);
    logic [31:0] t, s;
    t = pc;
    case (sel)
      2'd0: t = pc + 32'd4;
      2'd1: t = pc + off;
      2'd2: begin
        s = rs1 + off;
        t = s - (s % 32'd2);
      end
      default: t = pc;
    endcase
    flt = (sel == 2'd3) || ((t % 32'd4) != 0);
    return flt ? pc : t;
  endfunction

  task automatic idle_inputs();
    bus.mem_ack     = 1'b0;
    bus.mem_data    = 32'h0;
    bus.inst_accept = 1'b0;
    bus.pc_next_sel = 2'b00;
    bus.offset      = 32'h0;
    bus.reg_rs1     = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_req",     {31'd0, bus.mem_req},    32'd0);
    check("rst_valid",   {31'd0, bus.inst_valid}, 32'd0);
    check("rst_fault",   {31'd0, bus.fault},      32'd0);
    check("rst_inst",    bus.inst,                32'd0);
    check("rst_inst_pc", bus.inst_pc,             32'd0);
    check("rst_addr",    bus.mem_addr,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr, input int delay);
    int n = 0;
    int bad = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, bus.mem_req}, 32'd1);
    check("req_addr", bus.mem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr || bus.inst_valid !== 1'b0) bad++;
    end
    if (delay > 0) check("ack_stall_stable", bad, 32'd0);
    bus.mem_ack  = 1'b1;
    bus.mem_data = mem_word(exp_addr);
    @(negedge clk);
    bus.mem_ack  = 1'b0;
    bus.mem_data = $urandom;
    check("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("inst",       bus.inst,                mem_word(exp_addr));
    check("inst_pc",    bus.inst_pc,             exp_addr);
    check("req_drop",   {31'd0, bus.mem_req},    32'd0);
  endtask

  task automatic do_accept(input logic [1:0] sel, input logic [31:0] off, input logic [31:0] rs1,
                           input int hold, input bit exp_fault, input logic [31:0] exp_addr);
    logic [31:0] inst0, pc0;
    int bad = 0;
    inst0 = bus.inst;
    pc0   = bus.inst_pc;
    for (int i = 0; i < hold; i++) begin
      bus.pc_next_sel = 2'($urandom);
      bus.offset      = $urandom;
      bus.mem_ack     = 1'($urandom);
      @(negedge clk);
      if (bus.inst !== inst0 || bus.inst_pc !== pc0 || bus.inst_valid !== 1'b1 || bus.mem_req !== 1'b0) bad++;
    end
    bus.mem_ack = 1'b0;
    if (hold > 0) check("accept_stall_stable", bad, 32'd0);
    bus.inst_accept = 1'b1;
    bus.pc_next_sel = sel;
    bus.offset      = off;
    bus.reg_rs1     = rs1;
    @(negedge clk);
    bus.inst_accept = 1'b0;
    bus.pc_next_sel = 2'($urandom);
    bus.offset      = $urandom;
    check("valid_drop", {31'd0, bus.inst_valid}, 32'd0);
    check("fault",      {31'd0, bus.fault},      {31'd0, exp_fault});
    check("req_after",  {31'd0, bus.mem_req},    {31'd0, !exp_fault});
    check("addr_after", bus.mem_addr,            exp_addr);
    if (exp_fault) begin
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        bus.mem_ack     = 1'b1;
        bus.inst_accept = 1'b1;
        bus.pc_next_sel = 2'b00;
        @(negedge clk);
        if (bus.fault !== 1'b1 || bus.mem_req !== 1'b0 || bus.inst_valid !== 1'b0 ||
            bus.mem_addr !== exp_addr) bad++;
      end
      idle_inputs();
      check("fault_sticky", bad, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] pc, off, rs1, t;
    logic [1:0]  sel;
    bit          flt;
    int          r, bad;

    idle_inputs();
    vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0000_0004, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0000_0008, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0000_000C, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 32'h4,         32'h0,         32'h0000_0010, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 32'h3,         32'h0000_1001, 32'h0000_1004, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 32'hC,         32'hFFFF_FFF0, 32'hFFFF_FFFC, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 32'h6,         32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 2'd3, 32'h0,         32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 2'd2, 32'h0,         32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 2'd2, 32'h1,         32'h0000_001F, 32'h0000_0020, 1'b0};

    // Directed: reset, slow ack, long accept stall, long ack stall.
    do_reset();
    do_fetch(32'h0, 3);
    check("first_inst", bus.inst, 32'h0050_0093);
    do_accept(2'd0, 32'h0, 32'h0, 10, 1'b0, 32'h4);
    do_fetch(32'h4, 20);
    do_accept(2'd0, 32'h0, 32'h0, 0, 1'b0, 32'h8);
    do_fetch(32'h8, 0);
    do_accept(2'd0, 32'h0, 32'h0, 1, 1'b0, 32'hC);

    // Directed: reset asserted mid-FETCH, ack arriving right after release.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req",   {31'd0, bus.mem_req},    32'd0);
    check("async_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("async_rst_addr",  bus.mem_addr,            32'd0);
    @(negedge clk);
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("post_rst_req",   {31'd0, bus.mem_req},    32'd1);
    check("post_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("post_rst_addr",  bus.mem_addr,            32'd0);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b1) bad++;
    end
    check("post_rst_ack_ignored", bad, 32'd0);
    do_fetch(32'h0, 0);

    // Table: chained next-PC vectors from PC 0.
    do_reset();
    do_fetch(32'h0, 0);
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].rst_before) begin
        do_reset();
        do_fetch(32'h0, 1);
      end
      do_accept(vecs[v].sel, vecs[v].off, vecs[v].rs1, v % 3, vecs[v].exp_fault, vecs[v].exp_addr);
      if (!vecs[v].exp_fault) do_fetch(vecs[v].exp_addr, v % 2);
    end

    // Randomized run against the reference model.
    do_reset();
    pc = 32'h0;
    do_fetch(pc, $urandom_range(0, 4));
    for (int k = 0; k < 150; k++) begin
      r   = $urandom_range(0, 19);
      sel = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off = (r == 1) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rs1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      t   = model_next(pc, sel, off, rs1, flt);
      do_accept(sel, off, rs1, $urandom_range(0, 3), flt, t);
      if (flt) begin
        do_reset();
        pc = 32'h0;
      end else begin
        pc = t;
      end
      do_fetch(pc, $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the datapath controller and decoder.
- Owns the PC register and issues one instruction-memory request at a time over a req/ack handshake.
- Presents the fetched instruction word and its PC to decode, holding both stable until consumed.
- On accept, computes the next PC from the controller's 2-bit next-PC select (PC+4, PC+offset, RS1+offset) and flags misaligned or illegal targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset. Must be 4-byte aligned.
- WIDTH, 32: data and address width. Only 32 is supported.

Ports:
- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- o_MemReq  out  1  instruction-memory request.
- o_MemAddr  out  32  request address; equals the current PC.
- i_MemAck  in  1  memory response valid; sampled only while o_MemReq=1.
- i_MemData  in  32  instruction word; valid when i_MemAck=1.
- o_Inst  out  32  registered instruction to decode/controller.
- o_InstPC  out  32  PC of o_Inst.
- o_InstValid  out  1  o_Inst and o_InstPC are valid.
- i_InstAccept  in  1  downstream consumed the instruction; i_PCNextSel, i_Offset and i_RegRS1 are valid this cycle.
- i_PCNextSel  in  2  next-PC select: 00 = PC+4, 01 = PC+offset, 10 = RS1+offset, 11 = illegal.
- i_Offset  in  32  sign-extended branch/jump immediate from decode.
- i_RegRS1  in  32  RS1 register value, used for JALR.
- o_Fault  out  1  sticky fetch fault: misaligned target or illegal select.

Behaviour:
- Reset (asynchronous on i_Reset=0):
  - PC = RESET_VECTOR; state = IDLE.
  - o_MemReq = 0, o_InstValid = 0, o_Fault = 0, o_Inst = 0, o_InstPC = 0.
  - o_MemAddr tracks PC.
  - Any pending memory transaction is abandoned. An ack arriving while o_MemReq=0 is ignored.
- State machine: IDLE, FETCH, VALID, FAULT.
- IDLE: single cycle after reset release. Next state FETCH.
- FETCH:
  - o_MemReq = 1. o_MemAddr is held at PC and stays stable until ack.
  - On i_MemAck=1: o_Inst <= i_MemData, o_InstPC <= PC, go to VALID.
  - Minimum latency is ack in the first FETCH cycle, giving o_InstValid one cycle later. Ack wait is unbounded.
- VALID:
  - o_InstValid = 1, o_MemReq = 0. o_Inst and o_InstPC are held while i_InstAccept=0.
  - On i_InstAccept=1, the next PC is computed combinationally and registered (modulo 2^32, wrap-around allowed):
    - 00: PC+4
    - 01: o_InstPC + i_Offset
    - 10: (i_RegRS1 + i_Offset) with bit0 cleared
    - 11: fault
  - If the select is 11, or the computed target has [1:0] != 00: o_Fault <= 1, PC is unchanged, go to FAULT.
  - Otherwise PC <= target, o_InstValid <= 0, go to FETCH.
  - No back-to-back accept: there is at least one FETCH cycle between instructions (non-pipelined, one in flight).
- FAULT:
  - o_Fault = 1, o_MemReq = 0, o_InstValid = 0.
  - Exit only by reset. i_InstAccept and i_MemAck are ignored.
- i_InstAccept outside VALID is ignored.
- Simultaneous reset assertion with ack or accept: reset wins.
- All outputs are registered except o_MemAddr, which is a direct copy of the PC register.

Test Plan:
- Reset release; memory acks after 3 cycles with 32'h00500093 -> o_MemAddr = 0 during FETCH; o_InstValid rises 1 cycle after ack with o_Inst = 32'h00500093 and o_InstPC = 0.
- Sequential flow: accept with sel = 00 at PC 0x0, then 0x4, then 0x8 -> next requests go to 0x4, 0x8, 0xC; o_InstValid deasserts for at least one cycle between instructions.
- Branch and JALR:
  - PC = 0x10, sel = 01, offset = -8 -> next fetch at 0x08.
  - sel = 10, RS1 = 0x1001, offset = 0x3 -> next fetch at 0x1004 (bit0 cleared).
  - PC = 0xFFFF_FFFC, sel = 00 -> wraps to 0x0.
- Fault cases:
  - sel = 01, offset = 0x6 at PC 0x0 -> o_Fault = 1; no further o_MemReq; PC stays 0x0.
  - sel = 11 -> same fault response.
  - Only reset clears o_Fault.
- Stalls:
  - i_InstAccept held low for 10 cycles -> o_Inst and o_InstPC stable, no new request.
  - i_MemAck held low for 20 cycles -> o_MemReq = 1 and o_MemAddr stable throughout.
- Reset in FETCH with ack arriving in the first post-reset cycle -> ack ignored; PC = RESET_VECTOR; fresh request issued from the FETCH state.
